// File: rtl/adc_pkt_tx.sv
// Packet transmitter: streams the capture buffer out to the ADC_DATA pads,
// grouping words into packets with programmable inter-word and inter-packet spacing.
module adc_pkt_tx #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture_start,
  input  logic              capture_again,
  input  logic              buf_full,
  input  logic              self_test_mode,
  input  logic [7:0]        pktctrl_gap,
  input  logic [15:0]       pkt_data_length,
  input  logic [15:0]       pkt_idle_length,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] adc_data,
  output logic              adc_data_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, WAIT_FULL, RD, LOAD, WAIT, PKT_IDLE, FIN} state_t;

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   ramp;
  logic [15:0]         pcnt;
  logic [15:0]         wcnt;
  logic [7:0]          gap_q;
  logic [15:0]         dlen_q;
  logic [15:0]         idle_q;
  logic                st_q;
  logic                has_frame;
  logic                accept;
  logic                last_word;
  logic                pkt_end;

  assign accept    = (state == IDLE) && (capture_start || (capture_again && has_frame));
  assign last_word = &addr;
  assign pkt_end   = (pcnt == dlen_q);

  assign rd_en   = (state == RD);
  assign rd_addr = addr;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        // start takes priority over again when both arrive together
        if (capture_start)                     state_nx = WAIT_FULL;
        else if (capture_again && has_frame)   state_nx = RD;
      end
      WAIT_FULL: if (buf_full) state_nx = RD;
      RD:        state_nx = LOAD;
      LOAD: begin
        if (last_word)      state_nx = FIN;
        else if (pkt_end)   state_nx = (idle_q == 16'd0) ? RD : PKT_IDLE;
        else                state_nx = (gap_q == 8'd0) ? RD : WAIT;
      end
      // wcnt restarts at 0 on every LOAD, so the state lasts exactly limit cycles
      WAIT:     if (wcnt == {8'd0, gap_q} - 16'd1) state_nx = RD;
      PKT_IDLE: if (wcnt == idle_q - 16'd1)        state_nx = RD;
      FIN:      state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr           <= '0;
      ramp           <= '0;
      pcnt           <= '0;
      wcnt           <= '0;
      gap_q          <= '0;
      dlen_q         <= '0;
      idle_q         <= '0;
      st_q           <= 1'b0;
      has_frame      <= 1'b0;
      adc_data       <= '0;
      adc_data_valid <= 1'b0;
      done           <= 1'b0;
    end else begin
      adc_data_valid <= (state == LOAD);
      done           <= (state == FIN);
      if (accept) begin
        addr   <= '0;
        ramp   <= '0;
        pcnt   <= '0;
        gap_q  <= pktctrl_gap;
        dlen_q <= pkt_data_length;
        idle_q <= pkt_idle_length;
        st_q   <= self_test_mode;
      end
      case (state)
        LOAD: begin
          adc_data <= st_q ? ramp : rd_data;
          addr     <= addr + 1'b1;
          ramp     <= ramp + 1'b1;
          wcnt     <= '0;
          pcnt     <= pkt_end ? 16'd0 : pcnt + 16'd1;
        end
        WAIT, PKT_IDLE: wcnt <= wcnt + 16'd1;
        FIN:            has_frame <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_pkt_tx.sv
// Directed bench for adc_pkt_tx: frame table plus hand-written sequences for
// full-flag wait, start/again collisions and mid-frame reset.
module tb_adc_pkt_tx;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 18;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              capture_start, capture_again, buf_full, self_test_mode;
  logic [7:0]        pktctrl_gap;
  logic [15:0]       pkt_data_length, pkt_idle_length;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] adc_data;
  logic              adc_data_valid, busy, done;

  adc_pkt_tx #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .capture_start(capture_start), .capture_again(capture_again),
    .buf_full(buf_full), .self_test_mode(self_test_mode), .pktctrl_gap(pktctrl_gap),
    .pkt_data_length(pkt_data_length), .pkt_idle_length(pkt_idle_length),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .adc_data(adc_data),
    .adc_data_valid(adc_data_valid), .busy(busy), .done(done));

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(3 * i);
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          vt [64];
  logic [17:0] vd [64];
  int          nv = 0, ndone = 0, tdone = 0;
  logic        busy_at_done = 1'b0;

  always @(negedge clk) begin
    if (adc_data_valid && nv < 64) begin
      vt[nv] = cyc;
      vd[nv] = adc_data;
      nv++;
    end
    if (done) begin
      ndone++;
      tdone = cyc;
      busy_at_done = busy;
    end
  end

  int checks = 0, errors = 0, tstart = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    nv = 0;
    ndone = 0;
  endtask

  task automatic pulse(input logic s, input logic a);
    @(negedge clk);
    capture_start = s;
    capture_again = a;
    @(negedge clk);
    capture_start = 1'b0;
    capture_again = 1'b0;
    tstart = cyc;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (ndone > 0) seen = 1;
    end
    check({name, "_done_timeout"}, int'(seen), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_words(input int n);
    bit seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (nv >= n) seen = 1;
    end
    check("wait_words_timeout", int'(seen), 1);
  endtask

  typedef struct {
    logic        again;
    logic        st;
    logic [7:0]  gap;
    logic [15:0] dl;
    logic [15:0] idle;
    int          lat;    // start edge to first valid
    int          intra;  // word spacing inside a packet
    int          inter;  // word spacing across a packet boundary
  } vec_t;

  task automatic run_row(input string name, input vec_t v);
    pktctrl_gap     = v.gap;
    pkt_data_length = v.dl;
    pkt_idle_length = v.idle;
    self_test_mode  = v.st;
    buf_full        = 1'b1;
    clear_mon();
    pulse(!v.again, v.again);
    // config must be latched at acceptance; scramble the live inputs
    pktctrl_gap     = 8'd37;
    pkt_data_length = 16'd1;
    pkt_idle_length = 16'd50;
    self_test_mode  = ~v.st;
    wait_done(name);
    check({name, "_nwords"}, nv, DEPTH);
    check({name, "_latency"}, vt[0] - tstart, v.lat);
    for (int k = 0; k < DEPTH && k < nv; k++) begin
      check($sformatf("%s_data%0d", name, k), int'(vd[k]), v.st ? k : 3 * k);
      if (k > 0)
        check($sformatf("%s_space%0d", name, k), vt[k] - vt[k-1],
              (k % (int'(v.dl) + 1) == 0) ? v.inter : v.intra);
    end
    check({name, "_ndone"}, ndone, 1);
    check({name, "_done_time"}, tdone, vt[nv > 0 ? nv - 1 : 0] + 1);
    check({name, "_busy_at_done"}, int'(busy_at_done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  vec_t vec [6];
  int   rd_bad, busy_bad;

  initial begin
    vec[0] = '{1'b0, 1'b0, 8'd8, 16'd0, 16'd15, 3, 10, 17};
    vec[1] = '{1'b0, 1'b0, 8'd1, 16'd2, 16'd5,  3, 3,  7};
    vec[2] = '{1'b1, 1'b1, 8'd0, 16'd3, 16'd0,  2, 2,  2};
    vec[3] = '{1'b1, 1'b0, 8'd2, 16'd1, 16'd0,  2, 4,  2};
    vec[4] = '{1'b0, 1'b1, 8'd3, 16'd7, 16'd9,  3, 5,  11};
    vec[5] = '{1'b0, 1'b0, 8'd0, 16'd0, 16'd0,  3, 2,  2};

    rst = 1'b1; capture_start = 1'b0; capture_again = 1'b0; buf_full = 1'b0;
    self_test_mode = 1'b0; pktctrl_gap = '0; pkt_data_length = '0; pkt_idle_length = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", int'({rd_en, rd_addr, adc_data, adc_data_valid, busy, done}), 0);
    rst = 1'b0;

    // again with no completed frame is refused
    clear_mon();
    buf_full = 1'b1;
    pulse(1'b0, 1'b1);
    busy_bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy || rd_en) busy_bad++;
    end
    check("again_after_reset_busy", busy_bad, 0);
    check("again_after_reset_words", nv, 0);

    for (int r = 0; r < 5; r++) run_row($sformatf("row%0d", r), vec[r]);

    // full-flag wait
    buf_full = 1'b0; pktctrl_gap = 8'd0; pkt_data_length = 16'd7;
    pkt_idle_length = 16'd0; self_test_mode = 1'b0;
    clear_mon();
    pulse(1'b1, 1'b0);
    rd_bad = 0; busy_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (rd_en) rd_bad++;
      if (!busy) busy_bad++;
    end
    check("wfull_no_rd", rd_bad, 0);
    check("wfull_busy", busy_bad, 0);
    buf_full = 1'b1;
    tstart = cyc;
    wait_done("wfull");
    check("wfull_latency", vt[0] - tstart, 3);
    check("wfull_nwords", nv, DEPTH);
    check("wfull_last", int'(vd[DEPTH-1]), 21);

    // start+again together take the start path; mid-frame start is ignored
    buf_full = 1'b0;
    clear_mon();
    pulse(1'b1, 1'b1);
    rd_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (rd_en) rd_bad++;
    end
    check("collide_start_path", rd_bad, 0);
    check("collide_busy", int'(busy), 1);
    buf_full = 1'b1;
    wait_words(3);
    pulse(1'b1, 1'b0);
    wait_done("collide");
    repeat (10) @(negedge clk);
    check("collide_nwords", nv, DEPTH);
    check("collide_ndone", ndone, 1);
    check("collide_idle_after", int'(busy), 0);

    // mid-frame reset
    pktctrl_gap = 8'd1; pkt_data_length = 16'd0; pkt_idle_length = 16'd2;
    clear_mon();
    pulse(1'b1, 1'b0);
    wait_words(3);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", int'({rd_en, rd_addr, adc_data, adc_data_valid, busy, done}), 0);
    rst = 1'b0;
    clear_mon();
    pulse(1'b0, 1'b1);
    busy_bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy || rd_en) busy_bad++;
    end
    check("midrst_again_refused", busy_bad, 0);
    check("midrst_again_words", nv, 0);
    run_row("midrst_restart", vec[5]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
